// File: rtl/dsm_ctrl_pkg.sv
// Shared types and helpers for the delta-sigma feed controller.
package dsm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // Bits needed to hold a ramp shift in [0, ramp_len].
  function automatic int unsigned shift_w(input int unsigned ramp_len);
    return (ramp_len == 0) ? 1 : $clog2(ramp_len + 1);
  endfunction

endpackage

// File: rtl/dsm_tick_div.sv
// Modulator tick divider: one tick every CLK_DIV cycles while running, frozen on back-pressure.
module dsm_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic aclk,
  input  logic arst_n,
  input  logic run,
  input  logic freeze,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge aclk) begin
    if (!arst_n || !run) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = run && !freeze && (cnt == LAST);

endmodule

// File: rtl/dsm_feed_ctrl.sv
// Feeds input-rate PCM to the delta-sigma modulator at tick rate, holding each
// sample for OSR ticks and applying a shift-based soft start/stop ramp.
module dsm_feed_ctrl
  import dsm_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned OSR      = 64,
  parameter int unsigned RAMP_LEN = 8,
  parameter int unsigned UCNT_W   = 16
) (
  input  logic              aclk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic [WIDTH-1:0]  s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [WIDTH-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [1:0]        state_o,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam int unsigned SW = shift_w(RAMP_LEN);
  localparam int unsigned FW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [SW-1:0] SHIFT_MAX = SW'(RAMP_LEN);
  localparam logic [SW-1:0] SHIFT_PRE = SW'(RAMP_LEN - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(OSR - 1);

  state_t                   state, state_nxt;
  logic [SW-1:0]            shift, shift_nxt;
  logic [FW-1:0]            frm_cnt;
  logic signed [WIDTH-1:0]  cur, nxt;
  logic                     nxt_valid;
  logic                     tick, hs, boundary, accept, to_idle;

  dsm_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
    .aclk   (aclk),
    .arst_n (arst_n),
    .run    (state != IDLE),
    .freeze (m_axis_tvalid && !m_axis_tready),
    .tick   (tick)
  );

  assign hs            = m_axis_tvalid && m_axis_tready;
  assign boundary      = hs && (frm_cnt == FRM_LAST);
  assign s_axis_tready = (state != IDLE) && !nxt_valid;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign to_idle       = (state != IDLE) && (state_nxt == IDLE);
  assign state_o       = state;

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    unique case (state)
      IDLE: begin
        shift_nxt = SHIFT_MAX;
        if (enable) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable) begin
          state_nxt = RAMP_DOWN;
        end else if (shift == '0) begin
          state_nxt = RUN;
        end else if (boundary) begin
          shift_nxt = shift - SW'(1);
          if (shift == SW'(1)) state_nxt = RUN;
        end
      end
      RUN: begin
        shift_nxt = '0;
        if (!enable) state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (enable) begin
          state_nxt = RAMP_UP;
        end else if (boundary) begin
          if (shift == SHIFT_PRE || shift == SHIFT_MAX) begin
            shift_nxt = SHIFT_MAX;
            state_nxt = IDLE;
          end else begin
            shift_nxt = shift + SW'(1);
          end
        // Ramp already silent (entered from RAMP_UP at full shift): leave once the output is quiet.
        end else if (shift == SHIFT_MAX && !tick && (!m_axis_tvalid || hs)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state         <= IDLE;
      shift         <= SHIFT_MAX;
      frm_cnt       <= '0;
      cur           <= '0;
      nxt           <= '0;
      nxt_valid     <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      underrun_cnt  <= '0;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;

      if (state == IDLE)  frm_cnt <= '0;
      else if (hs)        frm_cnt <= boundary ? '0 : frm_cnt + FW'(1);

      if (to_idle) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
      end else if (tick) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= (shift == SHIFT_MAX) ? '0 : cur >>> shift;
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
      end

      if (to_idle) begin
        nxt_valid <= 1'b0;
      end else if (accept) begin
        nxt       <= s_axis_tdata;
        nxt_valid <= 1'b1;
      end else if (boundary) begin
        nxt_valid <= 1'b0;
      end

      if (to_idle)                    cur <= '0;
      else if (boundary && nxt_valid) cur <= nxt;

      if (boundary && !nxt_valid && state == RUN && underrun_cnt != '1)
        underrun_cnt <= underrun_cnt + UCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dsm_feed_ctrl.sv
// Self-checking bench for dsm_feed_ctrl: per-tick scoreboard fed from frame tables plus directed checks.
module tb_dsm_feed_ctrl;

  logic        aclk = 1'b0;
  logic        arst_n;
  logic        enable;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [1:0]  state_o;
  logic [15:0] underrun_cnt;

  dsm_feed_ctrl #(
    .WIDTH    (16),
    .CLK_DIV  (4),
    .OSR      (8),
    .RAMP_LEN (3),
    .UCNT_W   (16)
  ) dut (
    .aclk          (aclk),
    .arst_n        (arst_n),
    .enable        (enable),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .state_o       (state_o),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int unsigned n;
    logic [15:0] data;
  } seg_t;

  seg_t        run_a[16];
  seg_t        run_b[3];
  logic [15:0] exp_q[$];
  logic [15:0] exp_d;
  logic [15:0] held;
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  int unsigned hs_cnt = 0;
  int unsigned cyc = 0;
  int unsigned c1, c2, budget;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Returns just after the posedge following the n-th handshake.
  task automatic wait_hs(input int unsigned n);
    int unsigned b = 0;
    while (hs_cnt < n && b < 400) begin
      @(negedge aclk); #1;
      b++;
    end
    if (hs_cnt < n) begin
      total_cnt++;
      $display("FAIL wait_hs: reached %0d handshakes, required %0d", hs_cnt, n);
    end
    @(posedge aclk); #1;
  endtask

  // Scoreboard consumer: every accepted modulator tick pops one expectation.
  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      if (!arst_n) begin
        hs_cnt = 0;
      end else if (m_axis_tvalid && m_axis_tready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL sb_empty: tick %0d data 0x%0h, no expectation queued", hs_cnt, m_axis_tdata);
        end else begin
          exp_d = exp_q.pop_front();
          check($sformatf("tick%0d", hs_cnt), 32'(m_axis_tdata), 32'(exp_d));
        end
      end
    end
  end

  initial begin
    run_a[0]  = '{8,  16'h0000};
    run_a[1]  = '{8,  16'h1000};
    run_a[2]  = '{8,  16'h2000};
    run_a[3]  = '{40, 16'h4000};
    run_a[4]  = '{16, 16'hC000};
    run_a[5]  = '{8,  16'h4000};
    run_a[6]  = '{8,  16'h2000};
    run_a[7]  = '{8,  16'h1000};
    run_a[8]  = '{8,  16'h0000};
    run_a[9]  = '{8,  16'h1000};
    run_a[10] = '{8,  16'h2000};
    run_a[11] = '{8,  16'h4000};
    run_a[12] = '{8,  16'h2000};
    run_a[13] = '{8,  16'h1000};
    run_a[14] = '{8,  16'h2000};
    run_a[15] = '{4,  16'h4000};
    run_b[0]  = '{16, 16'h0000};
    run_b[1]  = '{8,  16'h1000};
    run_b[2]  = '{8,  16'h2000};

    arst_n = 1'b0; enable = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_underrun", 32'(underrun_cnt), 32'd0);

    // Ramp up on constant 0x4000
    arst_n = 1'b1; enable = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 16'h4000;
    for (int i = 0; i < 16; i++)
      for (int unsigned k = 0; k < run_a[i].n; k++) exp_q.push_back(run_a[i].data);
    wait_hs(25);
    check("run_state", 32'(state_o), 32'd2);
    wait_hs(32);
    check("run_underrun", 32'(underrun_cnt), 32'd0);

    // Starve the input for two frames
    wait_hs(36);
    s_axis_tvalid = 1'b0;
    wait_hs(58);
    check("underrun_2", 32'(underrun_cnt), 32'd2);
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'hC000;
    wait_hs(64);
    check("underrun_hold", 32'(underrun_cnt), 32'd2);

    // Back-pressure stall
    wait_hs(68);
    m_axis_tready = 1'b0; s_axis_tdata = 16'h4000;
    budget = 0;
    while (!m_axis_tvalid && budget < 10) begin
      @(negedge aclk); #1;
      budget++;
    end
    check("stall_tvalid_up", 32'(m_axis_tvalid), 32'd1);
    held = m_axis_tdata;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk); #1;
      check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("stall_tdata", 32'(m_axis_tdata), 32'(held));
    end
    check("stall_hs_cnt", hs_cnt, 32'd68);
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    wait_hs(69);
    c1 = cyc;
    wait_hs(70);
    c2 = cyc;
    check("post_stall_gap", c2 - c1, 32'd4);

    // Ramp down to IDLE
    wait_hs(84);
    enable = 1'b0;
    wait_hs(90);
    check("down_state", 32'(state_o), 32'd3);
    wait_hs(104);
    check("idle_state", 32'(state_o), 32'd0);
    check("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("idle_tready", 32'(s_axis_tready), 32'd0);
    check("idle_tdata", 32'(m_axis_tdata), 32'd0);
    repeat (6) @(posedge aclk);
    #1;
    check("idle_quiet", hs_cnt, 32'd104);
    check("idle_tvalid_held", 32'(m_axis_tvalid), 32'd0);

    // Re-enable mid ramp-down
    enable = 1'b1;
    wait_hs(132);
    enable = 1'b0;
    wait_hs(148);
    check("redown_state", 32'(state_o), 32'd3);
    enable = 1'b1;
    @(posedge aclk); #1;
    check("reup_state", 32'(state_o), 32'd1);
    wait_hs(161);
    check("rerun_state", 32'(state_o), 32'd2);

    // Reset mid-RUN with a buffered sample
    wait_hs(164);
    check("underrun_pre_rst", 32'(underrun_cnt), 32'd2);
    check("sb_drain_a", exp_q.size(), 32'd0);
    arst_n = 1'b0; s_axis_tvalid = 1'b0;
    @(posedge aclk); #1;
    check("mrst_state", 32'(state_o), 32'd0);
    check("mrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mrst_underrun", 32'(underrun_cnt), 32'd0);
    check("mrst_tready", 32'(s_axis_tready), 32'd0);
    @(posedge aclk); #1;
    exp_q.delete();
    for (int i = 0; i < 3; i++)
      for (int unsigned k = 0; k < run_b[i].n; k++) exp_q.push_back(run_b[i].data);
    arst_n = 1'b1;
    wait_hs(10);
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'h2000;
    wait_hs(32);
    check("b_state", 32'(state_o), 32'd2);
    check("b_underrun", 32'(underrun_cnt), 32'd0);
    check("sb_drain_b", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
